// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   fwd_sel_e    : forwarding mux select (regfile / M-stage ALU result / W result)
//   TUSE_NONE    : Tuse value meaning "operand not read"
//   *_DEF        : default HI/LO unit latencies and busy-counter width
//   reg_hazard   : true when a source must wait for a producer still in flight
//   fwd_select   : forwarding select for one source operand, M before W
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE    = 2'd3;
    localparam int         MULT_CYC_DEF = 5;
    localparam int         DIV_CYC_DEF  = 10;
    localparam int         CNT_W_DEF    = 4;

    // A Tuse of TUSE_NONE can never be below a 2-bit Tnew, so unused
    // operands drop out of the compare without a separate qualifier.
    function automatic logic reg_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return (src != 5'd0) && (src == dst) && (tuse < tnew);
    endfunction

    function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                            input logic [4:0] rd_m,
                                            input logic [1:0] tnew_m,
                                            input logic [4:0] rd_w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if ((src == rd_m) && (tnew_m == 2'd0)) begin
                sel = FWD_MEM;
            end else if (src == rd_w) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// HI/LO (mult/div) unit busy tracker.
//   clk, clr_n   : clock, async active-low reset
//   md_start_i   : mult/div issuing in E this cycle
//   md_div_i     : 1 = div/divu, 0 = mult/multu
//   md_busy_o    : unit busy, including the issue cycle itself
module md_busy_cnt
    import mips_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic md_start_i,
    input  logic md_div_i,
    output logic md_busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A start while still counting simply reloads; the D-stage stall keeps
    // a second HI/LO op from issuing, so this only matters for robustness.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start_i) begin
            cnt_d = md_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy_o = md_start_i | (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
//   clk, clr_n                 : clock, async active-low reset
//   rs_D, rt_D, Tuse_*_D       : D-stage sources and their Tuse
//   hilo_use_D                 : D-stage instruction touches HI/LO
//   rs_E, rt_E, rd_E, Tnew_E   : E-stage sources / destination / Tnew
//   rd_M, Tnew_M, rd_W         : M and W destinations
//   md_start_E, md_div_E       : mult/div issue in E
//   stall, flush_E             : hold PC/IF_ID and bubble ID_EX
//   fwd_{rs,rt}_{D,E}          : forwarding selects (fwd_sel_e encoding)
//   md_busy                    : HI/LO unit busy
//   stall_cnt                  : saturating count of stalled cycles
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic        hilo_use_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  rd_E,
    input  logic [1:0]  Tnew_E,
    input  logic [4:0]  rd_M,
    input  logic [1:0]  Tnew_M,
    input  logic [4:0]  rd_W,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        stall,
    output logic        flush_E,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic        stall_rs;
    logic        stall_rt;
    logic        stall_hilo;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk        (clk),
        .clr_n      (clr_n),
        .md_start_i (md_start_E),
        .md_div_i   (md_div_E),
        .md_busy_o  (md_busy)
    );

    always_comb begin
        stall_rs   = reg_hazard(rs_D, Tuse_rs_D, rd_E, Tnew_E)
                   | reg_hazard(rs_D, Tuse_rs_D, rd_M, Tnew_M);
        stall_rt   = reg_hazard(rt_D, Tuse_rt_D, rd_E, Tnew_E)
                   | reg_hazard(rt_D, Tuse_rt_D, rd_M, Tnew_M);
        stall_hilo = hilo_use_D & md_busy;
        stall      = stall_rs | stall_rt | stall_hilo;
        flush_E    = stall;
    end

    always_comb begin
        fwd_rs_D = fwd_select(rs_D, rd_M, Tnew_M, rd_W);
        fwd_rt_D = fwd_select(rt_D, rd_M, Tnew_M, rd_W);
        fwd_rs_E = fwd_select(rs_E, rd_M, Tnew_M, rd_W);
        fwd_rt_E = fwd_select(rt_E, rd_M, Tnew_M, rd_W);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E, rd_E, rd_M, rd_W;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
    logic        hilo_use_D, md_start_E, md_div_E;
    logic        stall, flush_E, md_busy;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .Tuse_rs_D  (Tuse_rs_D),
        .Tuse_rt_D  (Tuse_rt_D),
        .hilo_use_D (hilo_use_D),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .rd_E       (rd_E),
        .Tnew_E     (Tnew_E),
        .rd_M       (rd_M),
        .Tnew_M     (Tnew_M),
        .rd_W       (rd_W),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall      (stall),
        .flush_E    (flush_E),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic       rst_b;
        logic [4:0] rsd, rtd, rse, rte, rde, rdm, rdw;
        logic [1:0] tus, tut, tne, tnm;
        logic       hu, ms, md;
    } stim_t;

    typedef struct {
        logic        stall;
        logic [1:0]  frsd, frtd, frse, frte;
        logic        busy;
        logic [31:0] scnt;
    } exp_t;

    exp_t    exp_q[$];
    int      checks = 0;
    int      errors = 0;
    bit      done   = 0;

    // Reference state: cycle index, last cycle the HI/LO unit stays busy,
    // and the number of stalled clock edges so far.
    longint  cyc        = 0;
    longint  busy_until = -1;
    longint  m_scnt     = 0;

    function automatic logic m_haz(input int s, input int tuse, input int d, input int tnew);
        return (s != 0) && (s == d) && (tuse < tnew);
    endfunction

    function automatic logic [1:0] m_fwd(input int s, input int dm, input int tm, input int dw);
        if (s == 0) return 2'd0;
        if (s == dm && tm == 0) return 2'd1;
        if (s == dw) return 2'd2;
        return 2'd0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_b: 1'b1, rsd: 5'd0, rtd: 5'd0, rse: 5'd0, rte: 5'd0, rde: 5'd0,
              rdm: 5'd0, rdw: 5'd0, tus: 2'd3, tut: 2'd3, tne: 2'd0, tnm: 2'd0,
              hu: 1'b0, ms: 1'b0, md: 1'b0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic busy;
        @(negedge clk);
        clr_n      = s.rst_b;
        rs_D = s.rsd; rt_D = s.rtd; rs_E = s.rse; rt_E = s.rte;
        rd_E = s.rde; rd_M = s.rdm; rd_W = s.rdw;
        Tuse_rs_D = s.tus; Tuse_rt_D = s.tut; Tnew_E = s.tne; Tnew_M = s.tnm;
        hilo_use_D = s.hu; md_start_E = s.ms; md_div_E = s.md;
        if (!s.rst_b) begin
            busy_until = -1;
            m_scnt     = 0;
        end
        #1;
        busy    = s.ms || (cyc <= busy_until);
        e.busy  = busy;
        e.stall = m_haz(s.rsd, s.tus, s.rde, s.tne) || m_haz(s.rsd, s.tus, s.rdm, s.tnm) ||
                  m_haz(s.rtd, s.tut, s.rde, s.tne) || m_haz(s.rtd, s.tut, s.rdm, s.tnm) ||
                  (s.hu && busy);
        e.frsd  = m_fwd(s.rsd, s.rdm, s.tnm, s.rdw);
        e.frtd  = m_fwd(s.rtd, s.rdm, s.tnm, s.rdw);
        e.frse  = m_fwd(s.rse, s.rdm, s.tnm, s.rdw);
        e.frte  = m_fwd(s.rte, s.rdm, s.tnm, s.rdw);
        e.scnt  = 32'(m_scnt);
        exp_q.push_back(e);
        // Effect of the coming clock edge.
        if (s.rst_b) begin
            if (s.ms) busy_until = cyc + (s.md ? 10 : 5);
            if (e.stall && m_scnt < 64'hFFFF_FFFF) m_scnt = m_scnt + 1;
        end
        cyc = cyc + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: compares every cycle the DUT presents while expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",     32'(stall),     32'(e.stall));
                chk("flush_E",   32'(flush_E),   32'(e.stall));
                chk("fwd_rs_D",  32'(fwd_rs_D),  32'(e.frsd));
                chk("fwd_rt_D",  32'(fwd_rt_D),  32'(e.frtd));
                chk("fwd_rs_E",  32'(fwd_rs_E),  32'(e.frse));
                chk("fwd_rt_E",  32'(fwd_rt_E),  32'(e.frte));
                chk("md_busy",   32'(md_busy),   32'(e.busy));
                chk("stall_cnt", stall_cnt,      e.scnt);
            end
        end
    end

    initial begin
        stim_t s;
        clr_n = 1'b0;
        rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
        Tuse_rs_D = '0; Tuse_rt_D = '0; Tnew_E = '0; Tnew_M = '0;
        hilo_use_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;

        // Reset with all-zero inputs: every output 0.
        s = idle(); s.rst_b = 1'b0; s.tus = 2'd0; s.tut = 2'd0;
        step(s);
        step(s);

        // Load-use sequence.
        s = idle(); s.rsd = 5'd8; s.tus = 2'd1; s.rde = 5'd8; s.tne = 2'd2;
        step(s);
        s = idle(); s.rsd = 5'd8; s.tus = 2'd1; s.rdm = 5'd8; s.tnm = 2'd1;
        step(s);
        s = idle(); s.rsd = 5'd8; s.tus = 2'd0; s.rdm = 5'd8; s.tnm = 2'd1;
        step(s);
        s = idle(); s.rsd = 5'd8; s.tus = 2'd1; s.rdm = 5'd8; s.tnm = 2'd0;
        step(s);

        // Register 0 never hazards nor forwards.
        s = idle(); s.rsd = 5'd0; s.tus = 2'd0; s.rde = 5'd0; s.tne = 2'd2;
        step(s);
        s = idle(); s.rtd = 5'd0; s.tut = 2'd0; s.rdm = 5'd0; s.tnm = 2'd0; s.rdw = 5'd0;
        step(s);

        // M over W priority, then W alone.
        s = idle(); s.rte = 5'd5; s.rdm = 5'd5; s.tnm = 2'd0; s.rdw = 5'd5;
        step(s);
        s.rdm = 5'd6;
        step(s);
        s = idle(); s.rse = 5'd9; s.rdm = 5'd9; s.tnm = 2'd1; s.rdw = 5'd9;
        step(s);

        // Mult then div with mfhi waiting in D; fresh stall count first.
        s = idle(); s.rst_b = 1'b0;
        step(s);
        s = idle(); s.ms = 1'b1; s.md = 1'b0;
        step(s);
        s = idle(); s.hu = 1'b1;
        repeat (7) step(s);
        s = idle(); s.ms = 1'b1; s.md = 1'b1;
        step(s);
        s = idle(); s.hu = 1'b1;
        repeat (12) step(s);

        // Reset three cycles into a div, with mfhi in D.
        s = idle(); s.ms = 1'b1; s.md = 1'b1;
        step(s);
        s = idle(); s.hu = 1'b1;
        repeat (3) step(s);
        s.rst_b = 1'b0;
        step(s);
        s.rst_b = 1'b1;
        repeat (3) step(s);

        // Saturation: preload the stall counter just below full scale.
        @(negedge clk);
        #3;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_scnt = 64'hFFFF_FFFE;
        s = idle(); s.rsd = 5'd8; s.tus = 2'd0; s.rde = 5'd8; s.tne = 2'd2;
        repeat (4) step(s);
        s = idle();
        step(s);

        // Randomized traffic over a small register range to provoke matches.
        s = idle(); s.rst_b = 1'b0;
        step(s);
        for (int i = 0; i < 400; i++) begin
            s.rst_b = ($urandom_range(0, 63) != 0);
            s.rsd = 5'($urandom_range(0, 7)); s.rtd = 5'($urandom_range(0, 7));
            s.rse = 5'($urandom_range(0, 7)); s.rte = 5'($urandom_range(0, 7));
            s.rde = 5'($urandom_range(0, 7)); s.rdm = 5'($urandom_range(0, 7));
            s.rdw = 5'($urandom_range(0, 7));
            s.tus = 2'($urandom_range(0, 3)); s.tut = 2'($urandom_range(0, 3));
            s.tne = 2'($urandom_range(0, 3)); s.tnm = 2'($urandom_range(0, 3));
            s.hu  = ($urandom_range(0, 3) == 0);
            s.ms  = ($urandom_range(0, 9) == 0);
            s.md  = 1'($urandom_range(0, 1));
            step(s);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
